// File: rtl/hs_sync_pkg.sv
// hs_sync_pkg
// Shared types and constants for the four-phase request/acknowledge
// bus synchronizer receiver (hs_sync_rx) and its flop-chain helper.
//   hs_state_e      : receiver handshake state
//   MIN_SYNC_STAGES : smallest legal synchronizer depth
package hs_sync_pkg;

  localparam int MIN_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    HS_IDLE  = 2'b00,
    HS_VALID = 2'b01,
    HS_ACK   = 2'b10
  } hs_state_e;

endpackage

// File: rtl/ff_sync_chain.sv
// ff_sync_chain
// M-stage flop-chain synchronizer for WIDTH independent single-bit levels.
// Every stage resets to 0 on the synchronous active-low reset.
// Ports:
//   clk     in  destination clock
//   reset_n in  synchronous active-low reset
//   i_d     in  asynchronous input level(s)
//   o_q     out synchronized level(s), output of the last stage
module ff_sync_chain
  import hs_sync_pkg::*;
#(
  parameter int M     = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  // A chain shorter than the minimum gives no useful metastability margin.
  if (M < MIN_SYNC_STAGES) begin : g_bad_depth
    $fatal(1, "ff_sync_chain: M must be >= MIN_SYNC_STAGES");
  end

  logic [WIDTH-1:0] r_stage [M];

  // Shift the asynchronous level through the synchronizer stages.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < M; i++) begin
        r_stage[i] <= {WIDTH{1'b0}};
      end
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < M; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[M-1];

endmodule

// File: rtl/hs_sync_rx.sv
// hs_sync_rx
// Destination side of a four-phase req/ack bus synchronizer. The source
// request is synchronized through an M-stage chain; on its rise the source
// data (held stable by the source) is captured and offered on a valid/ready
// interface. Acceptance raises the acknowledge level, which drops once the
// synchronized request has gone low. One word per request high phase.
// Ports:
//   clk     in  destination clock
//   reset_n in  synchronous active-low reset
//   s_req   in  asynchronous request level from the source domain
//   s_data  in  source data bus, stable from s_req rise until ack seen
//   s_ack   out registered acknowledge level to the source domain
//   d_data  out captured word, stable while d_valid is high
//   d_valid out captured word available
//   d_ready in  consumer accepts the word
//   err     out sticky protocol error (request withdrawn before delivery)
// Optional build macro: HS_SYNC_ASSERT_EN compiles in protocol SVA checks.
module hs_sync_rx
  import hs_sync_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int M          = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  s_req,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ack,
  output logic [DATA_WIDTH-1:0] d_data,
  output logic                  d_valid,
  input  logic                  d_ready,
  output logic                  err
);

  logic                  w_req_s;
  hs_state_e             w_state_nxt;
  logic                  w_capture;
  logic                  w_err_set;

  hs_state_e             r_state;
  logic                  r_s_ack;
  logic                  r_d_valid;
  logic [DATA_WIDTH-1:0] r_d_data;
  logic                  r_err;

  ff_sync_chain #(
    .M     (M),
    .WIDTH (1)
  ) u_req_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (s_req),
    .o_q     (w_req_s)
  );

  // Handshake next-state decode plus capture and error strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      HS_IDLE: begin
        if (w_req_s) begin
          w_state_nxt = HS_VALID;
          w_capture   = 1'b1;
        end else begin
          w_state_nxt = HS_IDLE;
        end
      end
      HS_VALID: begin
        // A withdrawn request is flagged, but the word still goes out.
        if (!w_req_s) begin
          w_err_set = 1'b1;
        end else begin
          w_err_set = 1'b0;
        end
        if (d_ready) begin
          w_state_nxt = HS_ACK;
        end else begin
          w_state_nxt = HS_VALID;
        end
      end
      HS_ACK: begin
        // A still-high request is the same phase: never re-accepted here.
        if (!w_req_s) begin
          w_state_nxt = HS_IDLE;
        end else begin
          w_state_nxt = HS_ACK;
        end
      end
      default: begin
        w_state_nxt = HS_IDLE;
      end
    endcase
  end

  // State, registered handshake outputs, capture register and sticky error.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= HS_IDLE;
      r_s_ack   <= 1'b0;
      r_d_valid <= 1'b0;
      r_d_data  <= {DATA_WIDTH{1'b0}};
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      // Outputs decoded from next state so they leave flops glitch-free.
      r_d_valid <= (w_state_nxt == HS_VALID);
      r_s_ack   <= (w_state_nxt == HS_ACK);
      if (w_capture) begin
        r_d_data <= s_data;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  assign s_ack   = r_s_ack;
  assign d_valid = r_d_valid;
  assign d_data  = r_d_data;
  assign err     = r_err;

`ifdef HS_SYNC_ASSERT_EN
  a_src_data_stable: assert property (@(posedge clk) disable iff (!reset_n)
    (w_req_s && !r_s_ack) |-> $stable(s_data));
  a_dst_data_stable: assert property (@(posedge clk) disable iff (!reset_n)
    r_d_valid |=> $stable(r_d_data));
  a_valid_ack_excl: assert property (@(posedge clk) disable iff (!reset_n)
    !(r_d_valid && r_s_ack));
`endif

endmodule

// File: tb/tb_hs_sync_rx.sv
module tb_hs_sync_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters (M=2, DATA_WIDTH=8), directed scenarios.
  logic       a_reset_n, a_s_req, a_s_ack, a_d_valid, a_d_ready, a_err;
  logic [7:0] a_s_data, a_d_data;

  // Instance B: M=3, DATA_WIDTH=32, randomized sweep.
  logic        b_reset_n, b_s_req, b_s_ack, b_d_valid, b_d_ready, b_err;
  logic [31:0] b_s_data, b_d_data;

  int n_checks = 0;
  int n_fail   = 0;

  hs_sync_rx #(.DATA_WIDTH(8), .M(2)) u_dut_a (
    .clk(clk), .reset_n(a_reset_n), .s_req(a_s_req), .s_data(a_s_data),
    .s_ack(a_s_ack), .d_data(a_d_data), .d_valid(a_d_valid),
    .d_ready(a_d_ready), .err(a_err)
  );

  hs_sync_rx #(.DATA_WIDTH(32), .M(3)) u_dut_b (
    .clk(clk), .reset_n(b_reset_n), .s_req(b_s_req), .s_data(b_s_data),
    .s_ack(b_s_ack), .d_data(b_d_data), .d_valid(b_d_valid),
    .d_ready(b_d_ready), .err(b_err)
  );

  // Reset held with s_req high, then request latency of M=2 edges.
  task automatic test_reset();
    a_reset_n = 1'b0; a_s_req = 1'b1; a_s_data = 8'h77; a_d_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({a_s_ack, a_d_valid, a_d_data, a_err} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_values ack/valid/data/err=%b/%b/%h/%b required 0/0/00/0",
               a_s_ack, a_d_valid, a_d_data, a_err);
    end
    a_reset_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (a_d_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_latency_early d_valid=%b required 0", a_d_valid);
    end
    @(negedge clk);
    n_checks++;
    if (a_d_valid !== 1'b1 || a_d_data !== 8'h77) begin
      n_fail++;
      $display("FAIL reset_latency d_valid=%b d_data=%h required 1/77", a_d_valid, a_d_data);
    end
    a_d_ready = 1'b1;
    @(negedge clk);
    a_s_req = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Single transfer with d_ready held high.
  task automatic test_basic();
    a_d_ready = 1'b1; a_s_data = 8'hA5; a_s_req = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (a_d_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_early d_valid=%b required 0", a_d_valid);
    end
    @(negedge clk);
    n_checks++;
    if ({a_d_valid, a_s_ack, a_d_data} !== {1'b1, 1'b0, 8'hA5}) begin
      n_fail++;
      $display("FAIL basic_valid valid/ack/data=%b/%b/%h required 1/0/a5",
               a_d_valid, a_s_ack, a_d_data);
    end
    @(negedge clk);
    n_checks++;
    if ({a_d_valid, a_s_ack} !== 2'b01) begin
      n_fail++;
      $display("FAIL basic_accept valid/ack=%b/%b required 0/1", a_d_valid, a_s_ack);
    end
    a_s_req = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (a_s_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_ack_hold s_ack=%b required 1", a_s_ack);
    end
    @(negedge clk);
    n_checks++;
    if ({a_s_ack, a_d_valid, a_d_data, a_err} !== {1'b0, 1'b0, 8'hA5, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_ack_fall ack/valid/data/err=%b/%b/%h/%b required 0/0/a5/0",
               a_s_ack, a_d_valid, a_d_data, a_err);
    end
  endtask

  // Ten cycles of back-pressure, then acceptance.
  task automatic test_backpressure();
    a_d_ready = 1'b0; a_s_data = 8'h3C; a_s_req = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if ({a_d_valid, a_s_ack, a_d_data} !== {1'b1, 1'b0, 8'h3C}) begin
        n_fail++;
        $display("FAIL backpressure_hold cycle %0d valid/ack/data=%b/%b/%h required 1/0/3c",
                 i, a_d_valid, a_s_ack, a_d_data);
      end
      @(negedge clk);
    end
    a_d_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({a_d_valid, a_s_ack} !== 2'b01) begin
      n_fail++;
      $display("FAIL backpressure_release valid/ack=%b/%b required 0/1", a_d_valid, a_s_ack);
    end
    a_s_req = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (a_s_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_ack_fall s_ack=%b required 0", a_s_ack);
    end
  endtask

  // Request withdrawn while the word waits: sticky err, word still delivered.
  task automatic test_protocol_error();
    a_d_ready = 1'b0; a_s_data = 8'h96; a_s_req = 1'b1;
    repeat (3) @(negedge clk);
    a_s_req = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (a_err !== 1'b0) begin
      n_fail++;
      $display("FAIL perr_early err=%b required 0", a_err);
    end
    @(negedge clk);
    n_checks++;
    if ({a_err, a_d_valid} !== 2'b11) begin
      n_fail++;
      $display("FAIL perr_set err/valid=%b/%b required 1/1", a_err, a_d_valid);
    end
    a_d_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({a_d_valid, a_s_ack, a_d_data} !== {1'b0, 1'b1, 8'h96}) begin
      n_fail++;
      $display("FAIL perr_deliver valid/ack/data=%b/%b/%h required 0/1/96",
               a_d_valid, a_s_ack, a_d_data);
    end
    @(negedge clk);
    n_checks++;
    if ({a_s_ack, a_err} !== 2'b01) begin
      n_fail++;
      $display("FAIL perr_ack_pulse ack/err=%b/%b required 0/1", a_s_ack, a_err);
    end
    repeat (5) @(negedge clk);
  endtask

  // Long request high phase yields one word; next word needs a new phase.
  task automatic test_no_double();
    int pulses = 0;
    logic prev = 1'b0;
    logic [7:0] got = 8'h00;
    a_d_ready = 1'b1; a_s_data = 8'hC3; a_s_req = 1'b1;
    for (int i = 0; i < 58; i++) begin
      @(negedge clk);
      if (a_d_valid && !prev) pulses++;
      prev = a_d_valid;
    end
    n_checks++;
    if (pulses !== 1 || a_s_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL no_double pulses=%0d s_ack=%b required 1/1", pulses, a_s_ack);
    end
    a_s_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (a_d_valid && !prev) pulses++;
      prev = a_d_valid;
    end
    a_s_data = 8'h5A; a_s_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (a_d_valid && !prev) begin
        pulses++;
        got = a_d_data;
      end
      prev = a_d_valid;
    end
    n_checks++;
    if (pulses !== 2 || got !== 8'h5A) begin
      n_fail++;
      $display("FAIL second_word pulses=%0d data=%h required 2/5a", pulses, got);
    end
    a_s_req = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (a_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky err=%b required 1", a_err);
    end
  endtask

  // M=3 / 32-bit instance: random data and back-pressure, in-order scoreboard.
  task automatic test_sweep();
    logic [31:0] exp_q[$];
    logic [31:0] exp_w;
    logic [31:0] prev_data = 32'h0;
    logic prev_valid = 1'b0;
    int sent = 0;
    int delivered = 0;
    int cyc = 0;
    b_reset_n = 1'b0; b_s_req = 1'b0; b_s_data = 32'h0; b_d_ready = 1'b0;
    repeat (2) @(negedge clk);
    b_reset_n = 1'b1;
    while (delivered < 1000 && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      n_checks++;
      if (b_d_valid && b_s_ack) begin
        n_fail++;
        $display("FAIL sweep_excl cycle %0d d_valid and s_ack both 1", cyc);
      end
      if (b_d_valid && prev_valid) begin
        n_checks++;
        if (b_d_data !== prev_data) begin
          n_fail++;
          $display("FAIL sweep_hold d_data=%h required %h", b_d_data, prev_data);
        end
      end
      prev_valid = b_d_valid;
      prev_data  = b_d_data;
      b_d_ready = ($urandom_range(0, 3) != 0);
      if (b_d_valid && b_d_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sweep_extra_word d_data=%h required no word", b_d_data);
        end else begin
          exp_w = exp_q.pop_front();
          if (b_d_data !== exp_w) begin
            n_fail++;
            $display("FAIL sweep_data word %0d d_data=%h required %h", delivered, b_d_data, exp_w);
          end
        end
        delivered++;
      end
      if (!b_s_req && !b_s_ack && sent < 1000) begin
        b_s_data = $urandom;
        exp_q.push_back(b_s_data);
        b_s_req = 1'b1;
        sent++;
      end else if (b_s_req && b_s_ack) begin
        b_s_req = 1'b0;
      end
    end
    n_checks++;
    if (delivered != 1000 || exp_q.size() != 0 || b_err !== 1'b0) begin
      n_fail++;
      $display("FAIL sweep_total delivered=%0d pending=%0d err=%b cycles=%0d required 1000/0/0",
               delivered, exp_q.size(), b_err, cyc);
    end
  endtask

  initial begin
    b_reset_n = 1'b0; b_s_req = 1'b0; b_s_data = 32'h0; b_d_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_protocol_error();
    test_no_double();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
